// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered MIPS decode stage with load-use scoreboard, trap state and stall counter
module decode_stage #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2,
    parameter int PC_W     = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              trap_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_cad,
    output logic              out_gp_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [1:0]        out_pc_sel,
    output logic              out_illegal,
    output logic              trapped,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {RUN, TRAP} state_t;

    state_t state_q, state_d;

    logic [5:0] opc, fun;
    logic [4:0] f_rs, f_rt, f_rd;
    logic       unused_shamt;

    assign opc  = in_instr[31:26];
    assign f_rs = in_instr[25:21];
    assign f_rt = in_instr[20:16];
    assign f_rd = in_instr[15:11];
    assign fun  = in_instr[5:0];
    assign unused_shamt = ^in_instr[10:6];

    logic is_r, is_lw, is_sw, is_jal, is_jalr, is_jump, r_legal, legal;
    logic rd_rs, rd_rt, dec_we;
    logic [1:0]        dec_pc_sel;
    logic [REG_AW-1:0] dec_rs, dec_rt, dec_cad;

    assign is_r    = (opc == 6'b000000);
    assign is_lw   = (opc == 6'b100011);
    assign is_sw   = (opc == 6'b101011);
    assign is_jal  = (opc == 6'b000011);
    assign is_jalr = is_r & (fun == 6'b001001);
    assign is_jump = (opc[5:1] == 5'b00001);

    assign r_legal = (fun[5:3] == 3'b100) | (fun == 6'b000000) | (fun == 6'b000010) |
                     (fun == 6'b000011) | (fun == 6'b001000) | (fun == 6'b001001) |
                     (fun == 6'b101010) | (fun == 6'b101011);

    assign legal = (is_r & r_legal) | (opc[5:3] == 3'b001) | is_lw | is_sw |
                   (opc[5:1] == 5'b00010) | is_jump |
                   ((opc == 6'b000001) & (f_rt[4:1] == 4'b0000)) |
                   ((opc[5:1] == 5'b00011) & (f_rt == 5'b00000));

    assign dec_rs  = REG_AW'(f_rs);
    assign dec_rt  = REG_AW'(f_rt);
    assign dec_cad = (is_jal | is_jalr) ? REG_AW'(31) : (is_r ? REG_AW'(f_rd) : REG_AW'(f_rt));
    assign dec_we  = legal & ((opc[5:3] == 3'b001) | is_lw | is_jal | (is_r & (fun != 6'b001000)));
    assign rd_rs   = legal & ~is_jump;
    assign rd_rt   = legal & (is_r | (opc[5:1] == 5'b00010) | is_sw);

    always_comb begin
        dec_pc_sel = 2'b11;
        if (legal) begin
            if (is_r & ((fun == 6'b001000) | (fun == 6'b001001)))
                dec_pc_sel = 2'b00;
            else if ((opc[5:2] == 4'b0001) | (opc == 6'b000001))
                dec_pc_sel = 2'b01;
            else if (is_jump)
                dec_pc_sel = 2'b10;
        end
    end

    // Register 0 is never pending, so the lookup starts at index 1.
    logic [2:0] sb_q [NUM_REGS];
    logic [2:0] sb_d [NUM_REGS];
    logic       rs_busy, rt_busy, hazard, accept;

    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if ((dec_rs == REG_AW'(i)) && (sb_q[i] != 3'd0)) rs_busy = 1'b1;
            if ((dec_rt == REG_AW'(i)) && (sb_q[i] != 3'd0)) rt_busy = 1'b1;
        end
    end

    logic              out_valid_q;
    logic [PC_W-1:0]   out_pc_q;
    logic [REG_AW-1:0] out_rs_q, out_rt_q, out_cad_q;
    logic              out_gp_we_q, out_mem_rd_q, out_mem_wr_q, out_illegal_q;
    logic [1:0]        out_pc_sel_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign hazard   = in_valid & ((rd_rs & rs_busy) | (rd_rt & rt_busy));
    assign in_ready = (state_q == RUN) & ~flush & ~hazard & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_d[i] = sb_q[i];
            if (flush)
                sb_d[i] = 3'd0;
            else if (accept && is_lw && (i != 0) && (dec_cad == REG_AW'(i)))
                sb_d[i] = 3'(LOAD_LAT);
            else if (sb_q[i] != 3'd0)
                sb_d[i] = sb_q[i] - 3'd1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (state_q == RUN) && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && !legal) state_d = TRAP;
            TRAP:    if (trap_ack) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= 3'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NUM_REGS; i++) sb_q[i] <= sb_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_rs_q      <= '0;
            out_rt_q      <= '0;
            out_cad_q     <= '0;
            out_gp_we_q   <= 1'b0;
            out_mem_rd_q  <= 1'b0;
            out_mem_wr_q  <= 1'b0;
            out_pc_sel_q  <= 2'b00;
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_pc_q      <= in_pc;
            out_rs_q      <= dec_rs;
            out_rt_q      <= dec_rt;
            out_cad_q     <= dec_cad;
            out_gp_we_q   <= dec_we;
            out_mem_rd_q  <= legal & is_lw;
            out_mem_wr_q  <= legal & is_sw;
            out_pc_sel_q  <= dec_pc_sel;
            out_illegal_q <= ~legal;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_rs      = out_rs_q;
    assign out_rt      = out_rt_q;
    assign out_cad     = out_cad_q;
    assign out_gp_we   = out_gp_we_q;
    assign out_mem_rd  = out_mem_rd_q;
    assign out_mem_wr  = out_mem_wr_q;
    assign out_pc_sel  = out_pc_sel_q;
    assign out_illegal = out_illegal_q;
    assign trapped     = (state_q == TRAP);
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench for decode_stage against a cycle-level behavioural model
module tb_decode_stage;

    localparam int LOAD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        trap_ack = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [4:0]  out_rs, out_rt, out_cad;
    logic        out_gp_we, out_mem_rd, out_mem_wr, out_illegal, trapped;
    logic [1:0]  out_pc_sel;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    decode_stage #(
        .NUM_REGS(32), .REG_AW(5), .LOAD_LAT(LOAD_LAT), .PC_W(32), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .trap_ack(trap_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs(out_rs), .out_rt(out_rt), .out_cad(out_cad), .out_gp_we(out_gp_we),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_pc_sel(out_pc_sel),
        .out_illegal(out_illegal), .trapped(trapped), .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit       legal;
        bit [4:0] cad;
        bit       we, mrd, mwr, rd_rs, rd_rt;
        bit [1:0] pcsel;
    } dec_t;

    int n_vec = 0;
    int n_fail = 0;

    bit          m_trap, m_ov;
    logic [31:0] m_ins, m_pc;
    int          free_at [32];
    int          m_stall, cyc;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic [5:0] opc = ins[31:26];
        logic [5:0] fn  = ins[5:0];
        logic [4:0] rt  = ins[20:16];
        d.legal = 0; d.we = 0; d.mrd = 0; d.mwr = 0; d.rd_rs = 1; d.rd_rt = 0;
        d.pcsel = 2'd3;
        d.cad = (opc == 6'h00) ? ins[15:11] : rt;
        case (opc)
            6'h00: begin
                d.legal = (fn >= 6'd32 && fn <= 6'd39) || fn inside {6'd0, 6'd2, 6'd3, 6'd8, 6'd9, 6'd42, 6'd43};
                d.we = (fn != 6'd8); d.rd_rt = 1;
                if (fn == 6'd8 || fn == 6'd9) d.pcsel = 2'd0;
                if (fn == 6'd9) d.cad = 5'd31;
            end
            6'h01: begin d.legal = (rt < 5'd2); d.pcsel = 2'd1; end
            6'h02: begin d.legal = 1; d.pcsel = 2'd2; d.rd_rs = 0; end
            6'h03: begin d.legal = 1; d.pcsel = 2'd2; d.rd_rs = 0; d.we = 1; d.cad = 5'd31; end
            6'h04, 6'h05: begin d.legal = 1; d.pcsel = 2'd1; d.rd_rt = 1; end
            6'h06, 6'h07: begin d.legal = (rt == 5'd0); d.pcsel = 2'd1; end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin d.legal = 1; d.we = 1; end
            6'h23: begin d.legal = 1; d.we = 1; d.mrd = 1; end
            6'h2B: begin d.legal = 1; d.mwr = 1; d.rd_rt = 1; end
            default: d.legal = 0;
        endcase
        if (!d.legal) begin
            d.we = 0; d.mrd = 0; d.mwr = 0; d.pcsel = 2'd3; d.rd_rs = 0; d.rd_rt = 0;
        end
        return d;
    endfunction

    function automatic bit pend(input logic [4:0] r);
        return (r != 5'd0) && (cyc < free_at[r]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_trap = 0; m_ov = 0; m_stall = 0; m_ins = '0; m_pc = '0;
        foreach (free_at[i]) free_at[i] = 0;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic ack, input logic ordy, output bit acc);
        dec_t d, md;
        bit hz, rdy;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; trap_ack = ack; out_ready = ordy;
        #1;
        d   = decode(ins);
        hz  = v && ((d.rd_rs && pend(ins[25:21])) || (d.rd_rt && pend(ins[20:16])));
        rdy = !m_trap && !fl && !hz && (!m_ov || ordy);
        acc = v && rdy;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_ov);
        chk("trapped", trapped, m_trap);
        chk("stall_cnt", stall_cnt, m_stall);
        if (m_ov) begin
            md = decode(m_ins);
            chk("out_pc", out_pc, m_pc);
            chk("out_rs", out_rs, m_ins[25:21]);
            chk("out_rt", out_rt, m_ins[20:16]);
            chk("out_cad", out_cad, md.cad);
            chk("out_gp_we", out_gp_we, md.we);
            chk("out_mem_rd", out_mem_rd, md.mrd);
            chk("out_mem_wr", out_mem_wr, md.mwr);
            chk("out_pc_sel", out_pc_sel, md.pcsel);
            chk("out_illegal", out_illegal, !md.legal);
        end
        @(posedge clk);
        if (hz && !m_trap && !fl && m_stall < 65535) m_stall++;
        if (fl) foreach (free_at[i]) free_at[i] = cyc + 1;
        else if (acc && ins[31:26] == 6'h23 && d.cad != 5'd0) free_at[d.cad] = cyc + 1 + LOAD_LAT;
        if (fl) m_ov = 0;
        else if (acc) begin m_ov = 1; m_ins = ins; m_pc = pc; end
        else if (ordy) m_ov = 0;
        if (!m_trap && acc && !d.legal) m_trap = 1;
        else if (m_trap && ack) m_trap = 0;
        cyc++;
    endtask

    function automatic logic [31:0] gen();
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        imm = 16'($urandom);
        case ($urandom_range(0, 13))
            0, 12, 13: return {6'h23, a, b, imm};
            1:  return {6'h2B, a, b, imm};
            2:  return {6'h00, a, b, c, 5'd0, 6'h20};
            3:  return {6'h00, a, 15'd0, 6'h08};
            4:  return {6'h00, a, 5'd0, c, 5'd0, 6'h09};
            5:  return {6'h09, a, b, imm};
            6:  return {6'h04, a, b, imm};
            7:  return {6'h02, 26'($urandom)};
            8:  return {6'h03, 26'($urandom)};
            9:  return {6'h01, a, b, imm};
            10: return {6'h06, a, 5'($urandom_range(0, 1)), imm};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit acc;
        int stalls;
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_trapped", trapped, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_cad", out_cad, 0);
        chk("rst_out_pc_sel", out_pc_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 32'h24080005, 32'h100, 0, 0, 1, acc);
        #2;
        chk("addiu_valid", out_valid, 1);
        chk("addiu_cad", out_cad, 8);
        chk("addiu_we", out_gp_we, 1);
        chk("addiu_pc_sel", out_pc_sel, 2'b11);
        chk("addiu_illegal", out_illegal, 0);

        step(1, 32'h8C090000, 32'h104, 0, 0, 1, acc);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h01294020, 32'h108, 0, 0, 1, acc);
            if (acc) break;
            stalls++;
        end
        #2;
        chk("loaduse_stalls", stalls, 2);
        chk("loaduse_stall_cnt", stall_cnt, 2);

        step(1, 32'h8C000000, 32'h10C, 0, 0, 1, acc);
        step(1, 32'h00001020, 32'h110, 0, 0, 1, acc);
        chk("r0_no_stall", acc, 1);
        #2;
        chk("r0_stall_cnt", stall_cnt, 2);

        step(1, 32'h0C000010, 32'h114, 0, 0, 1, acc);
        #2;
        chk("jal_cad", out_cad, 31);
        chk("jal_we", out_gp_we, 1);
        chk("jal_pc_sel", out_pc_sel, 2'b10);
        step(1, 32'h03E00008, 32'h118, 0, 0, 1, acc);
        #2;
        chk("jr_we", out_gp_we, 0);
        chk("jr_pc_sel", out_pc_sel, 2'b00);

        step(1, 32'hFC000000, 32'h11C, 0, 0, 1, acc);
        #2;
        chk("ill_flag", out_illegal, 1);
        chk("ill_trapped", trapped, 1);
        repeat (2) step(1, 32'h24080005, 32'h120, 0, 0, 1, acc);
        #2;
        chk("trap_in_ready", in_ready, 0);
        step(0, 32'h0, 32'h0, 0, 1, 1, acc);
        #2;
        chk("trap_ack_exit", trapped, 0);

        step(1, 32'h24080005, 32'h200, 0, 0, 1, acc);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h24090007, 32'h204, 0, 0, 0, acc);
            #2;
            chk("hold_out_pc", out_pc, 32'h200);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        step(0, 32'h0, 32'h0, 0, 0, 1, acc);

        step(1, 32'h8C0A0000, 32'h300, 0, 0, 1, acc);
        step(1, 32'h014A5820, 32'h304, 1, 0, 1, acc);
        #2;
        chk("flush_out_valid", out_valid, 0);
        step(1, 32'h014A5820, 32'h304, 0, 0, 1, acc);
        chk("flush_clears_sb", acc, 1);
        #2;
        chk("flush_stall_cnt", stall_cnt, 2);

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 8, gen(), $urandom, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, acc);

        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_trapped", trapped, 0);
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_out_pc", out_pc, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 8, gen(), $urandom, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
